// File: rtl/noc_pkg.sv
// ============================================================================
//  Module   : noc_pkg
//  Purpose  : Shared mesh-NoC constants: flit/coordinate widths, output port
//             indices and header field positions.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package noc_pkg;

    localparam int NOC_DATA_WIDTH = 288;
    localparam int NOC_COORD_W    = 4;

    localparam int PORT_N     = 0;
    localparam int PORT_E     = 1;
    localparam int PORT_S     = 2;
    localparam int PORT_W     = 3;
    localparam int PORT_L     = 4;
    localparam int NUM_PORTS  = 5;

    // Header fields sit at the top of the flit; slot k occupies the k-th
    // COORD_W-wide field counted down from the MSB.
    localparam int HDR_DEST_X_SLOT = 0;
    localparam int HDR_DEST_Y_SLOT = 1;

    function automatic int hdr_field_msb(input int data_width, input int coord_w,
                                         input int slot);
        return data_width - 1 - slot * coord_w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/noc_route_compute.sv
// ============================================================================
//  Module   : noc_route_compute
//  Purpose  : Combinational dimension-balanced routing: picks the axis with the
//             larger remaining distance (X on ties) and emits a one-hot port.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module noc_route_compute
    import noc_pkg::*;
#(
    parameter int COORD_W = noc_pkg::NOC_COORD_W,
    parameter int POS_X   = 0,
    parameter int POS_Y   = 0
) (
    input  logic [COORD_W-1:0]   dest_x,
    input  logic [COORD_W-1:0]   dest_y,
    output logic [NUM_PORTS-1:0] route
);

    localparam logic [COORD_W:0] PX = (COORD_W+1)'(POS_X);
    localparam logic [COORD_W:0] PY = (COORD_W+1)'(POS_Y);

    logic [COORD_W:0] dest_x_ext;
    logic [COORD_W:0] dest_y_ext;
    logic [COORD_W:0] dx;
    logic [COORD_W:0] dy;

    always_comb begin
        dest_x_ext = {1'b0, dest_x};
        dest_y_ext = {1'b0, dest_y};
        // Subtract the smaller from the larger so no difference ever wraps.
        dx = (dest_x_ext >= PX) ? (dest_x_ext - PX) : (PX - dest_x_ext);
        dy = (dest_y_ext >= PY) ? (dest_y_ext - PY) : (PY - dest_y_ext);

        route = '0;
        if ((dx == '0) && (dy == '0)) begin
            route[PORT_L] = 1'b1;
        end else if (dx >= dy) begin
            if (dest_x_ext > PX) route[PORT_E] = 1'b1;
            else                 route[PORT_W] = 1'b1;
        end else begin
            if (dest_y_ext > PY) route[PORT_S] = 1'b1;
            else                 route[PORT_N] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/noc_inport.sv
// ============================================================================
//  Module   : noc_inport
//  Purpose  : Router input port: FIFO of {route, flit} with route computed at
//             enqueue, grant-driven pop, credit-free busy backpressure.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module noc_inport
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = noc_pkg::NOC_DATA_WIDTH,
    parameter int DEPTH      = 4,
    parameter int POS_X      = 0,
    parameter int POS_Y      = 0,
    parameter int COORD_W    = noc_pkg::NOC_COORD_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_flit,
    input  logic                  in_valid,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] head_flit,
    output logic [NUM_PORTS-1:0]  route_valid,
    input  logic [NUM_PORTS-1:0]  route_clear,
    output logic [1:0]            err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = DATA_WIDTH + NUM_PORTS;
    localparam int X_MSB = hdr_field_msb(DATA_WIDTH, COORD_W, HDR_DEST_X_SLOT);
    localparam int Y_MSB = hdr_field_msb(DATA_WIDTH, COORD_W, HDR_DEST_Y_SLOT);

    logic [EW-1:0]        mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q,  count_d;
    logic [1:0]           err_q,    err_d;

    logic [NUM_PORTS-1:0] new_route;
    logic [EW-1:0]        head_entry;
    logic                 empty;
    logic                 full;
    logic                 push;
    logic                 pop;

    noc_route_compute #(
        .COORD_W (COORD_W),
        .POS_X   (POS_X),
        .POS_Y   (POS_Y)
    ) u_route (
        .dest_x (in_flit[X_MSB -: COORD_W]),
        .dest_y (in_flit[Y_MSB -: COORD_W]),
        .route  (new_route)
    );

    assign head_entry = mem_q[rd_ptr_q];

    always_comb begin
        empty       = (count_q == '0);
        full        = (count_q == CW'(DEPTH));
        route_valid = empty ? '0 : head_entry[EW-1 -: NUM_PORTS];
        head_flit   = empty ? '0 : head_entry[DATA_WIDTH-1:0];
        // Counting the in-flight strobe leaves one slot for the flit the
        // registered upstream switch has already launched.
        busy        = ({1'b0, count_q} + {{CW{1'b0}}, in_valid}) >= (CW+1)'(DEPTH);

        pop  = |(route_clear & route_valid);
        push = in_valid && (!full || pop);

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);

        err_d    = err_q;
        err_d[0] = err_q[0] | (in_valid && full && !pop);
        err_d[1] = err_q[1] | (|(route_clear & ~route_valid));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {new_route, in_flit};
    end

    assign err = err_q;

endmodule

`default_nettype wire
